// File: rtl/sign_extend_stream.sv
// Streaming sign/zero extender with per-beat width and mode.
// Two-entry skid buffer gives full throughput under backpressure.
module sign_extend_stream #(
  parameter  int IN_W  = 8,
  parameter  int OUT_W = 32,
  parameter  int CNT_W = 16,
  localparam int LEN_W = $clog2(IN_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [LEN_W-1:0] in_len,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_neg,
  output logic [CNT_W-1:0] xfer_count
);

  typedef enum logic [1:0] {
    S_EMPTY,
    S_ONE,
    S_TWO
  } state_t;

  state_t             state_q, state_d;
  logic [OUT_W-1:0]   or_q, or_d;
  logic [OUT_W-1:0]   sr_q, sr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [LEN_W-1:0]   l_eff;
  logic [OUT_W-1:0]   pad;
  logic [OUT_W-1:0]   ext;
  logic               sign_b;
  logic               acc;
  logic               drn;

  // Width clamp: 0 or anything wider than the port means full width.
  always_comb begin
    if (in_len == '0 || in_len > LEN_W'(IN_W)) begin
      l_eff = LEN_W'(IN_W);
    end else begin
      l_eff = in_len;
    end
  end

  always_comb begin
    sign_b = 1'b0;
    for (int i = 0; i < IN_W; i++) begin
      if (i == int'(l_eff) - 1) begin
        sign_b = in_data[i];
      end
    end
  end

  always_comb begin
    pad = '0;
    pad[IN_W-1:0] = in_data;
    ext = '0;
    for (int i = 0; i < OUT_W; i++) begin
      if (i < int'(l_eff)) begin
        ext[i] = pad[i];
      end else begin
        ext[i] = in_mode & sign_b;
      end
    end
  end

  assign in_ready   = !rst && (state_q != S_TWO);
  assign out_valid  = (state_q != S_EMPTY);
  assign out_data   = or_q;
  assign out_neg    = or_q[OUT_W-1];
  assign xfer_count = cnt_q;

  assign acc = in_valid & in_ready;
  assign drn = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    or_d    = or_q;
    sr_d    = sr_q;
    unique case (state_q)
      S_EMPTY: begin
        if (acc) begin
          or_d    = ext;
          state_d = S_ONE;
        end
      end
      S_ONE: begin
        if (acc && drn) begin
          or_d = ext;
        end else if (acc) begin
          sr_d    = ext;
          state_d = S_TWO;
        end else if (drn) begin
          state_d = S_EMPTY;
        end
      end
      S_TWO: begin
        if (drn) begin
          or_d    = sr_q;
          state_d = S_ONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (drn && cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      or_q    <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      or_q    <= or_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_sign_extend_stream.sv
// Bench for sign_extend_stream: queue model, directed literals, random traffic.
// A second instance with a 4-bit counter shares all inputs.
module tb_sign_extend_stream;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic [3:0]  in_len = '0;
  logic        in_mode = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_neg;
  logic [31:0] out_data;
  logic [15:0] xfer_count;

  logic        s_in_ready, s_out_valid, s_out_neg;
  logic [31:0] s_out_data;
  logic [3:0]  s_xfer_count;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sign_extend_stream #(.IN_W(8), .OUT_W(32), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_len(in_len), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_neg(out_neg),
    .xfer_count(xfer_count)
  );

  sign_extend_stream #(.IN_W(8), .OUT_W(32), .CNT_W(4)) u_small (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .in_data(in_data), .in_len(in_len), .in_mode(in_mode),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_data(s_out_data), .out_neg(s_out_neg),
    .xfer_count(s_xfer_count)
  );

  // Reference model
  logic [31:0] mq[$];
  int          m_cnt = 0;
  int          m_cnt_s = 0;
  bit          m_zero = 1'b1;

  function automatic logic [31:0] model_ext(logic [7:0] d, int len, bit mode);
    int          l;
    logic [31:0] m;
    logic [31:0] v;
    l = (len == 0 || len > 8) ? 8 : len;
    m = (32'h1 << l) - 32'h1;
    v = {24'h0, d} & m;
    if (mode && d[l-1]) v = v | ~m;
    return v;
  endfunction

  always @(posedge clk) begin
    bit acc, drn;
    if (rst) begin
      mq.delete();
      m_cnt = 0;
      m_cnt_s = 0;
      m_zero = 1'b1;
    end else begin
      acc = in_valid && (mq.size() < 2);
      drn = (mq.size() > 0) && out_ready;
      if (drn) begin
        void'(mq.pop_front());
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt_s < 15) m_cnt_s++;
      end
      if (acc) begin
        mq.push_back(model_ext(in_data, int'(in_len), in_mode));
        m_zero = 1'b0;
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    bit exp_rdy;
    exp_rdy = !rst && (mq.size() < 2);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("s_in_ready", 32'(s_in_ready), 32'(exp_rdy));
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    chk("s_out_valid", 32'(s_out_valid), 32'(mq.size() > 0));
    chk("xfer_count", 32'(xfer_count), 32'(m_cnt));
    chk("s_xfer_count", 32'(s_xfer_count), 32'(m_cnt_s));
    if (mq.size() > 0) begin
      chk("out_data", out_data, mq[0]);
      chk("out_neg", 32'(out_neg), 32'(mq[0][31]));
      chk("s_out_data", s_out_data, mq[0]);
    end else if (m_zero) begin
      chk("out_data_rst", out_data, 32'h0);
      chk("out_neg_rst", 32'(out_neg), 32'h0);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    cycle();
    rst = 1'b0;
  endtask

  task automatic lit(logic [7:0] d, logic [3:0] l, bit m, logic [31:0] exp);
    in_data = d;
    in_len = l;
    in_mode = m;
    in_valid = 1'b1;
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("lit_valid", 32'(out_valid), 32'h1);
    chk("lit_data", out_data, exp);
    chk("lit_neg", 32'(out_neg), 32'(exp[31]));
    cycle();
  endtask

  initial begin
    cycle();
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_cnt", 32'(xfer_count), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h0);
    rst = 1'b0;
    cycle();
    chk("ready_after_rst", 32'(in_ready), 32'h1);

    // Directed extension literals
    lit(8'h03, 4'd3, 1'b1, 32'h0000_0003);
    lit(8'h05, 4'd3, 1'b1, 32'hFFFF_FFFD);
    lit(8'h05, 4'd3, 1'b0, 32'h0000_0005);
    lit(8'hF5, 4'd3, 1'b0, 32'h0000_0005);
    lit(8'h80, 4'd0, 1'b1, 32'hFFFF_FF80);
    lit(8'h80, 4'd12, 1'b1, 32'hFFFF_FF80);
    lit(8'hFF, 4'd1, 1'b1, 32'hFFFF_FFFF);
    lit(8'h7E, 4'd8, 1'b0, 32'h0000_007E);

    // Backpressure: A, B fill both slots, C is held
    do_reset();
    out_ready = 1'b0;
    in_mode = 1'b0;
    in_len = 4'd8;
    in_valid = 1'b1;
    in_data = 8'hA1;
    cycle();
    in_data = 8'hB2;
    cycle();
    chk("bp_ready_two", 32'(in_ready), 32'h0);
    in_data = 8'hC3;
    cycle();
    chk("bp_hold_a", out_data, 32'h0000_00A1);
    chk("bp_ready_hold", 32'(in_ready), 32'h0);
    out_ready = 1'b1;
    cycle();
    chk("bp_b", out_data, 32'h0000_00B2);
    chk("bp_ready_one", 32'(in_ready), 32'h1);
    cycle();
    chk("bp_c", out_data, 32'h0000_00C3);
    in_valid = 1'b0;
    cycle();
    chk("bp_cnt", 32'(xfer_count), 32'd3);
    chk("bp_empty", 32'(out_valid), 32'h0);

    // Reset while full and stalled
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h11;
    cycle();
    in_data = 8'h22;
    cycle();
    in_valid = 1'b0;
    rst = 1'b1;
    cycle();
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_data", out_data, 32'h0);
    chk("mid_rst_cnt", 32'(xfer_count), 32'h0);
    rst = 1'b0;
    out_ready = 1'b1;
    cycle();
    chk("mid_rst_ready", 32'(in_ready), 32'h1);
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("mid_rst_gone", 32'(out_valid), 32'h0);
    end

    // Sustained throughput and saturation of the small counter
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_data = 8'($urandom);
      in_len = 4'($urandom_range(0, 15));
      in_mode = 1'($urandom);
      cycle();
      chk("tp_ready", 32'(in_ready), 32'h1);
      chk("tp_valid", 32'(out_valid), 32'h1);
    end
    in_valid = 1'b0;
    cycle();
    chk("tp_cnt20", 32'(xfer_count), 32'd20);
    chk("tp_sat15", 32'(s_xfer_count), 32'd15);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      in_valid = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      in_data = 8'($urandom);
      in_len = 4'($urandom_range(0, 15));
      in_mode = 1'($urandom);
      cycle();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    cycle();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
